// File: rtl/path_replayer.sv
// path_replayer
//   Drains a 2-bit direction stack through its pop interface into a local buffer,
//   then replays the captured moves over a valid/ready stream.
//
//   Default build: moves are replayed in original push order (forward path).
//   With RETURN_PATH_EN defined: moves are replayed in pop order, each direction
//   inverted (MSB flipped), giving the path back to the starting point.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      begin drain+replay, sampled only while idle
//   stk_empty  stack empty flag
//   stk_data   stack read data, valid the cycle after stk_pop
//   stk_pop    one-cycle pop request to the stack
//   move_dir   direction offered to the consumer
//   move_valid move_dir is valid
//   move_ready consumer accepts on valid & ready at a clock edge
//   busy       high whenever not idle
//   done       one-cycle pulse at the end of an operation
//   path_len   number of entries captured, held until the next start
//   err        overflow flag, sticky until the next accepted start
module path_replayer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stk_empty,
    input  logic [DW-1:0]              stk_data,
    output logic                       stk_pop,
    output logic [DW-1:0]              move_dir,
    output logic                       move_valid,
    input  logic                       move_ready,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] path_len,
    output logic                       err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDrain   = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StReplay  = 3'd3;
    localparam logic [2:0] StFin     = 3'd4;

`ifdef RETURN_PATH_EN
    // Opposite direction is obtained by flipping the MSB (up<->down, right<->left).
    localparam logic [DW-1:0] DirFlip = DW'(1) << (DW - 1);
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] index_q, index_d;
    logic [DW-1:0] move_dir_q, move_dir_d;
    logic          move_valid_q, move_valid_d;
    logic [CW-1:0] path_len_q, path_len_d;
    logic          err_q, err_d;

    logic [DW-1:0] buf_mem [DEPTH];
    logic          buf_we;

    assign buf_we = (state_q == StCapture);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        move_dir_d   = move_dir_q;
        move_valid_d = move_valid_q;
        path_len_d   = path_len_q;
        err_d        = err_q;
        stk_pop      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StDrain;
                    count_d    = '0;
                    err_d      = 1'b0;
                    path_len_d = '0;
                end
            end
            StDrain: begin
                if (stk_empty) begin
                    path_len_d = count_q;
                    if (count_q != '0) begin
                        state_d      = StReplay;
                        move_valid_d = 1'b1;
`ifdef RETURN_PATH_EN
                        index_d    = '0;
                        move_dir_d = buf_mem[0] ^ DirFlip;
`else
                        index_d    = IW'(count_q - CW'(1));
                        move_dir_d = buf_mem[IW'(count_q - CW'(1))];
`endif
                    end else begin
                        state_d = StFin;
                    end
                end else if (count_q == CW'(DEPTH)) begin
                    // Stack holds more than the buffer can keep: abort without replay.
                    err_d      = 1'b1;
                    path_len_d = count_q;
                    state_d    = StFin;
                end else begin
                    stk_pop = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                count_d = count_q + CW'(1);
                state_d = StDrain;
            end
            StReplay: begin
                if (move_ready) begin
`ifdef RETURN_PATH_EN
                    if (index_q == IW'(count_q - CW'(1))) begin
                        move_valid_d = 1'b0;
                        state_d      = StFin;
                    end else begin
                        index_d    = index_q + IW'(1);
                        move_dir_d = buf_mem[index_q + IW'(1)] ^ DirFlip;
                    end
`else
                    if (index_q == '0) begin
                        move_valid_d = 1'b0;
                        state_d      = StFin;
                    end else begin
                        index_d    = index_q - IW'(1);
                        move_dir_d = buf_mem[index_q - IW'(1)];
                    end
`endif
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            index_q      <= '0;
            move_dir_q   <= '0;
            move_valid_q <= 1'b0;
            path_len_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            move_dir_q   <= move_dir_d;
            move_valid_q <= move_valid_d;
            path_len_q   <= path_len_d;
            err_q        <= err_d;
        end
    end

    // Buffer needs no reset; entries are always written before being read.
    // buf_mem[0] receives the top of stack, i.e. the most recently pushed move.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[count_q[IW-1:0]] <= stk_data;
        end
    end

    assign move_dir   = move_dir_q;
    assign move_valid = move_valid_q;
    assign path_len   = path_len_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFin);

endmodule

// File: tb/tb_path_replayer.sv
// Testbench for path_replayer (DEPTH=4): a stack model feeds the pop interface,
// a path model predicts the move stream, and every cycle's outputs are compared.
module tb_path_replayer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 2;
    localparam int unsigned PLW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           stk_empty = 1'b1;
    logic [DW-1:0]  stk_data = '0;
    logic           stk_pop;
    logic [DW-1:0]  move_dir;
    logic           move_valid;
    logic           move_ready = 1'b0;
    logic           busy;
    logic           done;
    logic [PLW-1:0] path_len;
    logic           err;

    path_replayer #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stk_empty (stk_empty),
        .stk_data  (stk_data),
        .stk_pop   (stk_pop),
        .move_dir  (move_dir),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .busy      (busy),
        .done      (done),
        .path_len  (path_len),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] stack_q[$];   // stack model, back = top
    logic [DW-1:0] push_q[$];    // pushes for the next operation, oldest first
    logic [DW-1:0] exp_arr[$];   // predicted move stream
    int  acc_cnt   = 0;          // moves accepted since time zero
    int  acc_base  = 0;
    int  pop_cnt   = 0;
    int  done_cnt  = 0;
    bit  prev_pop  = 0;
    bit  pop_pend  = 0;
    int  ready_pct = 100;
    int  stall_at  = -1;
    int  stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Path model: forward push order, or reversed and inverted for the return path.
    function automatic void build_model();
        exp_arr = {};
        if (push_q.size() <= DEPTH) begin
`ifdef RETURN_PATH_EN
            for (int i = push_q.size() - 1; i >= 0; i--) exp_arr.push_back(push_q[i] ^ 2'b10);
`else
            for (int i = 0; i < push_q.size(); i++) exp_arr.push_back(push_q[i]);
`endif
        end
    endfunction

    // One clock: update stack and drive ready after the edge, compare at negedge.
    task automatic cycle();
        int idx;
        @(posedge clk);
        #1;
        if (pop_pend && stack_q.size() > 0) stk_data = stack_q.pop_back();
        stk_empty = (stack_q.size() == 0);
        idx = acc_cnt - acc_base;
        if (move_valid && idx == stall_at && stall_left > 0) begin
            move_ready = 1'b0;
            stall_left--;
        end else begin
            move_ready = ($urandom_range(99) < ready_pct);
        end
        @(negedge clk);
        pop_pend = stk_pop;
        check("pop_back_to_back", {31'd0, stk_pop & prev_pop}, 0);
        prev_pop = stk_pop;
        pop_cnt  += int'(stk_pop);
        done_cnt += int'(done);
        if (move_valid) begin
            idx = acc_cnt - acc_base;
            if (idx >= exp_arr.size()) check("extra_move", 1, 0);
            else check("move_dir", move_dir, exp_arr[idx]);
            if (move_ready) acc_cnt++;
        end
    endtask

    task automatic run_op(input int pct, input int stall, input bit poke_start);
        int  n, ncap, k, first, k_done, pops0, done0;
        bit  ovf, seen_done;
        n     = push_q.size();
        ovf   = (n > DEPTH);
        ncap  = ovf ? DEPTH : n;
        build_model();
        stack_q    = push_q;
        stk_empty  = (stack_q.size() == 0);
        ready_pct  = pct;
        stall_at   = stall;
        stall_left = (stall >= 0) ? 3 : 0;
        acc_base   = acc_cnt;
        pops0      = pop_cnt;
        done0      = done_cnt;
        first      = -1;
        k_done     = -1;
        seen_done  = 0;
        start = 1'b1;
        cycle();
        k = 1;
        start = 1'b0;
        if (move_valid) first = k;
        if (done) begin seen_done = 1; k_done = k; end
        while (!seen_done && k < 400) begin
            start = (poke_start && k == 1);
            cycle();
            k++;
            if (move_valid && first < 0) first = k;
            if (done) begin seen_done = 1; k_done = k; end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen_done}, 1);
        if (exp_arr.size() > 0) check("first_move_latency", first, 2 * ncap + 2);
        else check("no_move_valid", first, -1);
        if (exp_arr.size() == 0) check("done_cycle", k_done, 2 * ncap + 2);
        else if (pct == 100) check("done_cycle", k_done,
                                   3 * ncap + 2 + ((stall >= 0) ? 3 : 0));
        check("pop_count", pop_cnt - pops0, ncap);
        check("moves_accepted", acc_cnt - acc_base, exp_arr.size());
        check("err", {31'd0, err}, {31'd0, ovf});
        if (!ovf) check("path_len", path_len, ncap);
        cycle();
        check("busy_after_done", {31'd0, busy}, 0);
        check("done_pulses", done_cnt - done0, 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) cycle();
        check("rst_stk_pop", {31'd0, stk_pop}, 0);
        check("rst_move_valid", {31'd0, move_valid}, 0);
        check("rst_move_dir", move_dir, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_path_len", path_len, 0);
        rst = 1'b1;
        cycle();

        // Basic replay, model pinned against hand-computed moves
        push_q = '{2'b01, 2'b10, 2'b11};
        build_model();
        check("model_len_basic", exp_arr.size(), 3);
`ifdef RETURN_PATH_EN
        check("model_basic0", exp_arr[0], 2'b01);
        check("model_basic1", exp_arr[1], 2'b00);
        check("model_basic2", exp_arr[2], 2'b11);
`else
        check("model_basic0", exp_arr[0], 2'b01);
        check("model_basic1", exp_arr[1], 2'b10);
        check("model_basic2", exp_arr[2], 2'b11);
`endif
        run_op(100, -1, 0);

        // Empty stack
        push_q = {};
        run_op(100, -1, 0);

        // Backpressure: 3 stall cycles on the second move
        push_q = '{2'b00, 2'b01, 2'b10};
        build_model();
`ifdef RETURN_PATH_EN
        check("model_bp1", exp_arr[1], 2'b11);
`else
        check("model_bp1", exp_arr[1], 2'b01);
`endif
        run_op(100, 1, 0);

        // Overflow, then a following start must clear err
        push_q = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        run_op(100, -1, 0);
        push_q = '{2'b10, 2'b01};
        run_op(100, -1, 0);

        // Reset during replay, after the first move has been accepted
        push_q = '{2'b01, 2'b11, 2'b00};
        build_model();
        stack_q   = push_q;
        stk_empty = 1'b0;
        ready_pct = 100;
        stall_at  = -1;
        acc_base  = acc_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 40 && (acc_cnt - acc_base) < 1; i++) cycle();
        check("reset_reached_replay", acc_cnt - acc_base, 1);
        cycle();
        rst = 1'b0;
        cycle();
        check("midrst_move_valid", {31'd0, move_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_path_len", path_len, 0);
        rst = 1'b1;
        cycle();

        // Start pulsed during DRAIN must be ignored
        push_q = '{2'b11, 2'b00, 2'b10};
        run_op(100, -1, 1);

        // Randomized operations
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(DEPTH + 1, 0);
            push_q = {};
            for (int i = 0; i < n; i++) push_q.push_back(DW'($urandom_range(3, 0)));
            run_op((t % 3 == 0) ? 100 : int'($urandom_range(100, 30)), -1, t[0]);
            repeat ($urandom_range(2, 0)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
